// File: rtl/vga_fb_arbiter_if.sv
// Bundle of the display-fetch, host-write and framebuffer-RAM signals around the arbiter.
// The slave side is the arbiter; the master side is whatever drives requests and models the RAM.
interface vga_fb_arbiter_if #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 3,
    parameter int WBUF_DEPTH = 4
);
    localparam int LVL_W = $clog2(WBUF_DEPTH) + 1;

    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_rdata;
    logic              disp_rvalid;
    logic              disp_miss;
    logic              host_wvalid;
    logic [ADDR_W-1:0] host_waddr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_wready;
    logic [LVL_W-1:0]  wbuf_level;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  disp_req, disp_addr, host_wvalid, host_waddr, host_wdata, mem_rdata,
        output disp_rdata, disp_rvalid, disp_miss, host_wready, wbuf_level,
        output mem_addr, mem_we, mem_wdata
    );

    modport master (
        output disp_req, disp_addr, host_wvalid, host_waddr, host_wdata, mem_rdata,
        input  disp_rdata, disp_rvalid, disp_miss, host_wready, wbuf_level,
        input  mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scan-out reads win, host writes are posted in a FIFO
// and drained in free slots, with an optional starvation guard that steals a display slot.
module vga_fb_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 3,
    parameter int WBUF_DEPTH = 4,
    parameter int STARVE_MAX = 0
) (
    input logic             clk,
    input logic             reset,
    vga_fb_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'd0,
        SLOT_DISP  = 2'd1,
        SLOT_HOST  = 2'd2,
        SLOT_FORCE = 2'd3
    } slot_t;

    logic [ADDR_W-1:0] wbuf_addr_r [WBUF_DEPTH];
    logic [DATA_W-1:0] wbuf_data_r [WBUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [LVL_W-1:0]  level_r, level_next_s;
    logic              wready_r;
    logic [CNT_W-1:0]  starve_cnt_r, starve_cnt_next_s;
    slot_t             slot_s;
    logic              nonempty_s, push_s, pop_s;
    logic [ADDR_W-1:0] mem_addr_next_s, mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_next_s, mem_wdata_r;
    logic              mem_we_next_s, mem_we_r;
    logic              miss_r, rd_v1_r, rd_v2_r, rvalid_r;
    logic [DATA_W-1:0] rdata_r;

    // Slot decision for this cycle, FIFO occupancy and starve counter next state.
    always_comb begin
        nonempty_s = (level_r != {LVL_W{1'b0}});
        if ((STARVE_MAX > 0) && nonempty_s && (starve_cnt_r == CNT_W'(STARVE_MAX))) begin
            slot_s = SLOT_FORCE;
        end else if (bus.disp_req) begin
            slot_s = SLOT_DISP;
        end else if (nonempty_s) begin
            slot_s = SLOT_HOST;
        end else begin
            slot_s = SLOT_IDLE;
        end

        pop_s  = (slot_s == SLOT_HOST) || (slot_s == SLOT_FORCE);
        push_s = bus.host_wvalid && wready_r;

        case ({push_s, pop_s})
            2'b10:   level_next_s = level_r + LVL_W'(1);
            2'b01:   level_next_s = level_r - LVL_W'(1);
            default: level_next_s = level_r;
        endcase

        if (!nonempty_s || pop_s) begin
            starve_cnt_next_s = {CNT_W{1'b0}};
        end else if (starve_cnt_r != CNT_W'(STARVE_MAX)) begin
            starve_cnt_next_s = starve_cnt_r + CNT_W'(1);
        end else begin
            starve_cnt_next_s = starve_cnt_r;
        end
    end

    // RAM command for the slot; read and idle slots never carry write data.
    always_comb begin
        mem_addr_next_s  = {ADDR_W{1'b0}};
        mem_wdata_next_s = {DATA_W{1'b0}};
        mem_we_next_s    = 1'b0;
        case (slot_s)
            SLOT_DISP: begin
                mem_addr_next_s = bus.disp_addr;
            end
            SLOT_HOST, SLOT_FORCE: begin
                mem_addr_next_s  = wbuf_addr_r[rd_ptr_r];
                mem_wdata_next_s = wbuf_data_r[rd_ptr_r];
                mem_we_next_s    = 1'b1;
            end
            default: begin
                mem_addr_next_s = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Write-buffer storage; contents are don't-care while the level says empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            wbuf_addr_r[wr_ptr_r] <= bus.host_waddr;
            wbuf_data_r[wr_ptr_r] <= bus.host_wdata;
        end
    end

    // Control state, RAM command registers and the three-stage read-return pipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            level_r      <= {LVL_W{1'b0}};
            wready_r     <= 1'b0;
            starve_cnt_r <= {CNT_W{1'b0}};
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= {DATA_W{1'b0}};
            mem_we_r     <= 1'b0;
            miss_r       <= 1'b0;
            rd_v1_r      <= 1'b0;
            rd_v2_r      <= 1'b0;
            rvalid_r     <= 1'b0;
            rdata_r      <= {DATA_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            level_r      <= level_next_s;
            wready_r     <= (level_next_s < LVL_W'(WBUF_DEPTH));
            starve_cnt_r <= starve_cnt_next_s;
            mem_addr_r   <= mem_addr_next_s;
            mem_wdata_r  <= mem_wdata_next_s;
            mem_we_r     <= mem_we_next_s;
            miss_r       <= (slot_s == SLOT_FORCE) && bus.disp_req;
            rd_v1_r      <= (slot_s == SLOT_DISP);
            rd_v2_r      <= rd_v1_r;
            rvalid_r     <= rd_v2_r;
            rdata_r      <= rd_v2_r ? bus.mem_rdata : {DATA_W{1'b0}};
        end
    end

    assign bus.mem_addr    = mem_addr_r;
    assign bus.mem_we      = mem_we_r;
    assign bus.mem_wdata   = mem_wdata_r;
    assign bus.disp_rdata  = rdata_r;
    assign bus.disp_rvalid = rvalid_r;
    assign bus.disp_miss   = miss_r;
    assign bus.host_wready = wready_r;
    assign bus.wbuf_level  = level_r;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: two instances (guard off, guard at 8) share one stimulus stream
// and are compared every cycle against a queue-based model of slot rules and RAM contents.
module tb_vga_fb_arbiter;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 3;
    localparam int DEPTH  = 4;
    localparam int MEM_N  = 16384;

    logic clk = 1'b0;
    logic reset;
    logic ram_init;

    always #10 clk = ~clk;

    vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WBUF_DEPTH(DEPTH)) bus0 ();
    vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WBUF_DEPTH(DEPTH)) bus1 ();

    vga_fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WBUF_DEPTH(DEPTH), .STARVE_MAX(0))
        dut0 (.clk(clk), .reset(reset), .bus(bus0));
    vga_fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WBUF_DEPTH(DEPTH), .STARVE_MAX(8))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));

    function automatic logic [2:0] pat(input int a);
        logic [13:0] v;
        v = a[13:0];
        return v[2:0] ^ v[5:3];
    endfunction

    function automatic int smax(input int i);
        return (i == 0) ? 0 : 8;
    endfunction

    // Synchronous read-first RAM behind each instance.
    logic [2:0] ram0 [MEM_N];
    logic [2:0] ram1 [MEM_N];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < MEM_N; i++) ram0[i] <= pat(i);
        end else if (bus0.mem_we) begin
            ram0[bus0.mem_addr] <= bus0.mem_wdata;
        end
        bus0.mem_rdata <= ram0[bus0.mem_addr];
    end
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < MEM_N; i++) ram1[i] <= pat(i);
        end else if (bus1.mem_we) begin
            ram1[bus1.mem_addr] <= bus1.mem_wdata;
        end
        bus1.mem_rdata <= ram1[bus1.mem_addr];
    end

    // Reference model state, one slot per instance.
    logic [16:0] wq     [2][$];
    int          rv_due [2][$];
    logic [2:0]  rv_dat [2][$];
    logic [2:0]  shadow [2][MEM_N];
    int          starve [2];
    logic [13:0] e_addr [2];
    logic        e_we [2];
    logic [2:0]  e_wdata [2];
    logic        e_miss [2];
    int          e_level [2];
    logic        e_wready [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int miss_seen = 0;
    bit armed  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_outputs(input int i);
        logic [13:0] o_addr;
        logic        o_we, o_miss, o_rv, o_wready, x_rv;
        logic [2:0]  o_wdata, o_rd, x_rd;
        logic [2:0]  o_lvl;
        if (i == 0) begin
            o_addr = bus0.mem_addr; o_we = bus0.mem_we; o_wdata = bus0.mem_wdata;
            o_miss = bus0.disp_miss; o_rv = bus0.disp_rvalid; o_rd = bus0.disp_rdata;
            o_wready = bus0.host_wready; o_lvl = bus0.wbuf_level;
        end else begin
            o_addr = bus1.mem_addr; o_we = bus1.mem_we; o_wdata = bus1.mem_wdata;
            o_miss = bus1.disp_miss; o_rv = bus1.disp_rvalid; o_rd = bus1.disp_rdata;
            o_wready = bus1.host_wready; o_lvl = bus1.wbuf_level;
        end
        x_rv = 1'b0;
        x_rd = 3'd0;
        if (rv_due[i].size() > 0 && rv_due[i][0] == cyc) begin
            x_rv = 1'b1;
            x_rd = rv_dat[i][0];
            void'(rv_due[i].pop_front());
            void'(rv_dat[i].pop_front());
        end
        if (o_miss === 1'b1) miss_seen++;
        chk($sformatf("d%0d.mem_addr", i),    32'(o_addr),   32'(e_addr[i]));
        chk($sformatf("d%0d.mem_we", i),      32'(o_we),     32'(e_we[i]));
        chk($sformatf("d%0d.mem_wdata", i),   32'(o_wdata),  32'(e_wdata[i]));
        chk($sformatf("d%0d.disp_miss", i),   32'(o_miss),   32'(e_miss[i]));
        chk($sformatf("d%0d.wbuf_level", i),  32'(o_lvl),    32'(e_level[i]));
        chk($sformatf("d%0d.host_wready", i), 32'(o_wready), 32'(e_wready[i]));
        chk($sformatf("d%0d.disp_rvalid", i), 32'(o_rv),     32'(x_rv));
        chk($sformatf("d%0d.disp_rdata", i),  32'(o_rd),     32'(x_rd));
    endtask

    // One cycle of the arbitration rules applied to the model of instance i.
    task automatic model_step(input int i, input logic rst, input logic dreq, input logic [13:0] da,
                              input logic wv, input logic [13:0] wa, input logic [2:0] wd);
        logic        push, frc;
        logic [16:0] head;
        int          sm;
        sm = smax(i);
        e_addr[i] = 14'd0; e_we[i] = 1'b0; e_wdata[i] = 3'd0; e_miss[i] = 1'b0;
        if (rst) begin
            wq[i].delete(); rv_due[i].delete(); rv_dat[i].delete();
            starve[i] = 0; e_level[i] = 0; e_wready[i] = 1'b0;
            return;
        end
        push = wv && e_wready[i];
        frc  = (sm > 0) && (wq[i].size() > 0) && (starve[i] == sm);
        if (frc || (!dreq && wq[i].size() > 0)) begin
            head = wq[i].pop_front();
            e_addr[i] = head[16:3]; e_wdata[i] = head[2:0]; e_we[i] = 1'b1;
            shadow[i][head[16:3]] = head[2:0];
            e_miss[i] = frc && dreq;
            starve[i] = 0;
        end else if (dreq) begin
            e_addr[i] = da;
            rv_due[i].push_back(cyc + 3);
            rv_dat[i].push_back(shadow[i][da]);
            if (wq[i].size() == 0) starve[i] = 0;
            else if (starve[i] < sm) starve[i]++;
        end else begin
            starve[i] = 0;
        end
        if (push) wq[i].push_back({wa, wd});
        e_level[i]  = wq[i].size();
        e_wready[i] = (wq[i].size() < DEPTH);
    endtask

    task automatic step(input logic rst, input logic dreq, input logic [13:0] da,
                        input logic wv, input logic [13:0] wa, input logic [2:0] wd);
        if (armed) begin
            check_outputs(0);
            check_outputs(1);
        end
        reset = rst;
        bus0.disp_req = dreq; bus0.disp_addr = da;
        bus0.host_wvalid = wv; bus0.host_waddr = wa; bus0.host_wdata = wd;
        bus1.disp_req = dreq; bus1.disp_addr = da;
        bus1.host_wvalid = wv; bus1.host_waddr = wa; bus1.host_wdata = wd;
        model_step(0, rst, dreq, da, wv, wa, wd);
        model_step(1, rst, dreq, da, wv, wa, wd);
        if (rst) armed = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 14'd0, 1'b0, 14'd0, 3'd0);
    endtask

    initial begin
        logic [13:0] ra, wa;
        ram_init = 1'b1;
        for (int i = 0; i < MEM_N; i++) begin
            shadow[0][i] = pat(i);
            shadow[1][i] = pat(i);
        end
        step(1'b1, 1'b0, 14'd0, 1'b0, 14'd0, 3'd0);
        step(1'b1, 1'b0, 14'd0, 1'b0, 14'd0, 3'd0);
        ram_init = 1'b0;

        idle(10);
        step(1'b0, 1'b1, 14'h0005, 1'b0, 14'd0, 3'd0);
        idle(5);
        step(1'b0, 1'b0, 14'd0, 1'b1, 14'h1234, 3'b011);
        idle(4);

        for (int k = 0; k < 5; k++) begin
            ra = 14'(k * 7);
            step(1'b0, 1'b1, ra, 1'b1, 14'(16'h0100 + k), 3'(k + 1));
        end
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 14'(k), 1'b0, 14'd0, 3'd0);
        idle(8);

        step(1'b0, 1'b1, 14'h0020, 1'b1, 14'h0abc, 3'b110);
        for (int k = 0; k < 14; k++) step(1'b0, 1'b1, 14'(16'h0021 + k), 1'b0, 14'd0, 3'd0);
        idle(5);

        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 14'(16'h0040 + k), 1'b1, 14'(16'h0200 + k), 3'(k));
        step(1'b1, 1'b1, 14'h0050, 1'b1, 14'h0300, 3'b111);
        idle(5);

        for (int k = 0; k < 3000; k++) begin
            ra = ($urandom_range(0, 1) == 0) ? 14'($urandom_range(0, 15)) : 14'($urandom);
            wa = ($urandom_range(0, 1) == 0) ? 14'($urandom_range(0, 15)) : 14'($urandom);
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), ra,
                 ($urandom_range(0, 1) == 1), wa, 3'($urandom));
        end
        idle(6);
        chk("d1.starve_guard_exercised", 32'(miss_seen > 0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
